// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the asynchronous FIFO: read pointer, empty/level and
// RAM fetch sequencing. Optional almost_empty output under FIFO_RD_ALMOST_EMPTY_EN.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  R_clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   sync_wptr,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic                  almost_empty
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_e;

  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   rbin_q, rbin_d;
  logic [ADDR_WIDTH:0]   rgray_q, rgray_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH:0]   wbin;

  assign wbin      = gray2bin(sync_wptr);
  assign empty     = (rgray_q == sync_wptr);
  assign level     = wbin - rbin_q;
  assign rd_addr   = rbin_q[ADDR_WIDTH-1:0];
  assign rptr_gray = rgray_q;
  assign out_data  = out_data_q;
  assign out_valid = (state_q == VALID);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          rd_en   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        out_data_d = mem_rdata;
        state_d    = VALID;
      end
      VALID: begin
        if (out_ready) begin
          if (!empty) begin
            rd_en   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // The RAM strobe must stay quiet while reset is held, even with a non-zero wptr.
    if (rst) rd_en = 1'b0;
  end

  assign rbin_d  = rbin_q + {{ADDR_WIDTH{1'b0}}, rd_en};
  assign rgray_d = rbin_d ^ (rbin_d >> 1);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge R_clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rbin_q     <= '0;
      rgray_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rbin_q     <= rbin_d;
      rgray_q    <= rgray_d;
      out_data_q <= out_data_d;
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic [ADDR_WIDTH:0] level_next;
  logic                almost_empty_q;

  assign level_next   = level - {{ADDR_WIDTH{1'b0}}, rd_en};
  assign almost_empty = almost_empty_q;

  always_ff @(posedge R_clk or posedge rst) begin
    if (rst) almost_empty_q <= 1'b1;
    else     almost_empty_q <= (32'(level_next) <= AE_LEVEL);
  end
`endif

endmodule
